// File: rtl/ghash_seq_pkg.sv
// Shared GCM definitions: sequencer state encoding, reduction constant,
// length-field width and the byte-padding helpers.
package ghash_seq_pkg;

    localparam int LEN_W   = 64;
    localparam int MUL_LAT = 128;

    // Reduction polynomial constant, bit-reflected as the multiplier uses it.
    localparam logic [127:0] GCM_R = {8'hE1, 120'h0};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACCEPT  = 3'd1,
        ST_MUL     = 3'd2,
        ST_LEN     = 3'd3,
        ST_MUL_LEN = 3'd4
    } state_e;

    // A byte count outside 1..16 is malformed.
    function automatic logic nbytes_bad(input logic [4:0] n);
        return (n == 5'd0) || (n > 5'd16);
    endfunction

    // Malformed byte counts are treated as a full block.
    function automatic logic [4:0] nbytes_eff(input logic [4:0] n);
        return nbytes_bad(n) ? 5'd16 : n;
    endfunction

    // Keep bytes 0..n-1 (byte 0 in bits [127:120]); clear the rest.
    function automatic logic [127:0] byte_mask(input logic [4:0] n);
        logic [127:0] m;
        logic [4:0]   ne;
        ne = nbytes_eff(n);
        m  = 128'h0;
        for (int i = 0; i < 16; i++) begin
            if (5'(i) < ne) begin
                m[127 - 8*i -: 8] = 8'hFF;
            end else begin
                m[127 - 8*i -: 8] = 8'h00;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/ghash_seq_if.sv
// Block input handshake plus multiplier operand/result bus of the GHASH sequencer.
interface ghash_seq_if;
    logic [127:0] iBlock;
    logic [4:0]   iBlock_nbytes;
    logic         iBlock_aad;
    logic         iBlock_last;
    logic         iBlock_valid;
    logic         oBlock_ready;
    logic [127:0] oMul_x;
    logic         oMul_valid;
    logic [127:0] iMul_result;
    logic         iMul_done;

    // Sequencer side.
    modport slave (
        input  iBlock, iBlock_nbytes, iBlock_aad, iBlock_last, iBlock_valid,
        output oBlock_ready,
        output oMul_x, oMul_valid,
        input  iMul_result, iMul_done
    );

    // GCM top level / multiplier side.
    modport master (
        output iBlock, iBlock_nbytes, iBlock_aad, iBlock_last, iBlock_valid,
        input  oBlock_ready,
        input  oMul_x, oMul_valid,
        output iMul_result, iMul_done
    );
endinterface

// File: rtl/ghash_seq_len_ctr.sv
// Bit-length accumulators for the AAD and ciphertext parts, with detection of
// an AAD block arriving after ciphertext has started.
module ghash_seq_len_ctr
    import ghash_seq_pkg::*;
(
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             clr_i,
    input  logic             acc_i,
    input  logic             aad_i,
    input  logic [4:0]       nbytes_i,
    output logic [LEN_W-1:0] len_a_o,
    output logic [LEN_W-1:0] len_c_o,
    output logic             order_err_o
);

    logic [LEN_W-1:0] len_a_q, len_a_d;
    logic [LEN_W-1:0] len_c_q, len_c_d;
    logic             seen_c_q, seen_c_d;
    logic [LEN_W-1:0] bits_s;

    assign bits_s = LEN_W'({nbytes_i, 3'b000});

    // Next-state: clear at message start, otherwise add 8*nbytes to the selected part (wraps).
    always_comb begin
        len_a_d  = len_a_q;
        len_c_d  = len_c_q;
        seen_c_d = seen_c_q;
        if (clr_i) begin
            len_a_d  = {LEN_W{1'b0}};
            len_c_d  = {LEN_W{1'b0}};
            seen_c_d = 1'b0;
        end else if (acc_i) begin
            if (aad_i) begin
                len_a_d = len_a_q + bits_s;
            end else begin
                len_c_d  = len_c_q + bits_s;
                seen_c_d = 1'b1;
            end
        end else begin
            seen_c_d = seen_c_q;
        end
    end

    // Counter registers with synchronous active-low reset.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            len_a_q  <= {LEN_W{1'b0}};
            len_c_q  <= {LEN_W{1'b0}};
            seen_c_q <= 1'b0;
        end else begin
            len_a_q  <= len_a_d;
            len_c_q  <= len_c_d;
            seen_c_q <= seen_c_d;
        end
    end

    assign len_a_o     = len_a_q;
    assign len_c_o     = len_c_q;
    assign order_err_o = acc_i & aad_i & seen_c_q;

endmodule

// File: rtl/ghash_seq.sv
// GHASH sequencer: pads each block, folds it into Y, runs Y^X through the
// external multiplier, then hashes the length block and presents S.
module ghash_seq
    import ghash_seq_pkg::*;
(
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iStart,
    ghash_seq_if.slave        bus,
    output logic [127:0]      oGhash,
    output logic              oGhash_valid,
    output logic              oErr
);

    state_e           state_q, state_d;
    logic [127:0]     y_q, y_d;
    logic [127:0]     x_q, x_d;
    logic             mv_q, mv_d;
    logic             rdy_q, rdy_d;
    logic             last_q, last_d;
    logic [127:0]     ghash_q, ghash_d;
    logic             gv_q, gv_d;
    logic             err_q, err_d;

    logic             clr_s;
    logic             accept_s;
    logic             order_err_s;
    logic [127:0]     xpad_s;
    logic [LEN_W-1:0] len_a_s, len_c_s;

    assign clr_s    = (state_q == ST_IDLE) & iStart;
    assign accept_s = (state_q == ST_ACCEPT) & rdy_q & bus.iBlock_valid;
    assign xpad_s   = bus.iBlock & byte_mask(bus.iBlock_nbytes);

    ghash_seq_len_ctr u_len_ctr (
        .iClk        (iClk),
        .iRst_n      (iRst_n),
        .clr_i       (clr_s),
        .acc_i       (accept_s),
        .aad_i       (bus.iBlock_aad),
        .nbytes_i    (nbytes_eff(bus.iBlock_nbytes)),
        .len_a_o     (len_a_s),
        .len_c_o     (len_c_s),
        .order_err_o (order_err_s)
    );

    // Next-state and datapath updates; ready/valid are decoded from the next state so they register with it.
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        x_d     = x_q;
        last_d  = last_q;
        ghash_d = ghash_q;
        gv_d    = 1'b0;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    state_d = ST_ACCEPT;
                    y_d     = 128'h0;
                    last_d  = 1'b0;
                    ghash_d = 128'h0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCEPT: begin
                if (accept_s) begin
                    x_d     = y_q ^ xpad_s;
                    last_d  = bus.iBlock_last;
                    err_d   = err_q | nbytes_bad(bus.iBlock_nbytes) | order_err_s;
                    state_d = ST_MUL;
                end else begin
                    state_d = ST_ACCEPT;
                end
            end
            ST_MUL: begin
                if (bus.iMul_done) begin
                    y_d     = bus.iMul_result;
                    state_d = last_q ? ST_LEN : ST_ACCEPT;
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_LEN: begin
                x_d     = y_q ^ {len_a_s, len_c_s};
                state_d = ST_MUL_LEN;
            end
            ST_MUL_LEN: begin
                if (bus.iMul_done) begin
                    ghash_d = bus.iMul_result;
                    gv_d    = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_MUL_LEN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        rdy_d = (state_d == ST_ACCEPT);
        mv_d  = (state_d == ST_MUL) | (state_d == ST_MUL_LEN);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state_q <= ST_IDLE;
            y_q     <= 128'h0;
            x_q     <= 128'h0;
            mv_q    <= 1'b0;
            rdy_q   <= 1'b0;
            last_q  <= 1'b0;
            ghash_q <= 128'h0;
            gv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            x_q     <= x_d;
            mv_q    <= mv_d;
            rdy_q   <= rdy_d;
            last_q  <= last_d;
            ghash_q <= ghash_d;
            gv_q    <= gv_d;
            err_q   <= err_d;
        end
    end

    assign bus.oBlock_ready = rdy_q;
    assign bus.oMul_x       = x_q;
    assign bus.oMul_valid   = mv_q;
    assign oGhash           = ghash_q;
    assign oGhash_valid     = gv_q;
    assign oErr             = err_q;

endmodule
